// File: rtl/udp_rx_parser.sv
// IPv4/UDP receive filter: strips IP/UDP headers, trims Ethernet padding, emits payload with metadata.
// Optional IPv4 header checksum verification is built when UDP_RX_IP_CSUM_EN is defined.
module udp_rx_parser #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8010A,
  parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        header_valid,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  output logic        header_rd,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        meta_valid,
  output logic [47:0] meta_src_mac,
  output logic [31:0] meta_src_ip,
  output logic [15:0] meta_src_port,
  output logic [15:0] meta_len,
  output logic [15:0] drop_count
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {IDLE, IP_HDR, UDP_HDR, PAYLOAD, DROP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               reject;
  logic [47:0]        mac_q;
  logic [31:0]        ip_q;
  logic [15:0]        port_q;
  logic [15:0]        len_q;
  logic [15:0]        remaining;

  logic               accept;
  logic               ip_bad;
  logic               udp_bad;
  logic               csum_bad;
  logic [15:0]        drop_inc;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign drop_inc = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;

  // Input acceptance: payload is throttled by the single-entry output register.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      IP_HDR, UDP_HDR, DROP: s_axis_tready = 1'b1;
      PAYLOAD:               s_axis_tready = ~m_axis_tvalid | m_axis_tready;
      default:               s_axis_tready = 1'b0;
    endcase
  end

  // Per-byte IPv4 header field checks (DF bit in byte 6 is allowed).
  always_comb begin
    ip_bad = 1'b0;
    case (cnt)
      5'd0:    ip_bad = (s_axis_tdata != 8'h45);
      5'd6:    ip_bad = ((s_axis_tdata & 8'h3F) != 8'h00);
      5'd7:    ip_bad = (s_axis_tdata != 8'h00);
      5'd9:    ip_bad = (s_axis_tdata != 8'd17);
      5'd16:   ip_bad = (s_axis_tdata != LOCAL_IP[31:24]);
      5'd17:   ip_bad = (s_axis_tdata != LOCAL_IP[23:16]);
      5'd18:   ip_bad = (s_axis_tdata != LOCAL_IP[15:8]);
      5'd19:   ip_bad = (s_axis_tdata != LOCAL_IP[7:0]);
      default: ip_bad = 1'b0;
    endcase
  end

  always_comb begin
    udp_bad = 1'b0;
    case (cnt)
      5'd2:    udp_bad = (s_axis_tdata != LOCAL_PORT[15:8]);
      5'd3:    udp_bad = (s_axis_tdata != LOCAL_PORT[7:0]);
      5'd5:    udp_bad = ({len_q[7:0], s_axis_tdata} < 16'd8);
      default: udp_bad = 1'b0;
    endcase
  end

`ifdef UDP_RX_IP_CSUM_EN
  logic [15:0] csum_q;
  logic [7:0]  csum_hi;
  logic [16:0] csum_add;
  logic [15:0] csum_nxt;

  // Ones-complement accumulation with end-around carry; one fold is sufficient.
  always_comb begin
    csum_add = {1'b0, csum_q} + {1'b0, csum_hi, s_axis_tdata};
    csum_nxt = csum_add[15:0] + 16'(csum_add[16]);
    csum_bad = (cnt == 5'd19) && (csum_nxt != 16'hFFFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q  <= '0;
      csum_hi <= '0;
    end else if (state == IDLE) begin
      csum_q  <= '0;
    end else if (state == IP_HDR && accept) begin
      if (!cnt[0]) csum_hi <= s_axis_tdata;
      else         csum_q  <= csum_nxt;
    end
  end
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      reject        <= 1'b0;
      mac_q         <= '0;
      ip_q          <= '0;
      port_q        <= '0;
      len_q         <= '0;
      remaining     <= '0;
      header_rd     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      meta_valid    <= 1'b0;
      meta_src_mac  <= '0;
      meta_src_ip   <= '0;
      meta_src_port <= '0;
      meta_len      <= '0;
      drop_count    <= '0;
    end else begin
      header_rd  <= 1'b0;
      meta_valid <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          cnt    <= '0;
          reject <= 1'b0;
          if (header_valid) begin
            header_rd <= 1'b1;
            mac_q     <= src_mac;
            if (ethertype != 16'h0800) begin
              state      <= DROP;
              drop_count <= drop_inc;
            end else begin
              state <= IP_HDR;
            end
          end
        end

        IP_HDR: begin
          if (accept) begin
            cnt    <= cnt + 5'd1;
            reject <= reject | ip_bad;
            if (cnt >= 5'd12 && cnt <= 5'd15) ip_q <= {ip_q[23:0], s_axis_tdata};
            // A frame ending inside the headers takes precedence over any reject.
            if (s_axis_tlast) begin
              state      <= IDLE;
              drop_count <= drop_inc;
            end else if (cnt == 5'd19) begin
              cnt    <= '0;
              reject <= 1'b0;
              if (reject || ip_bad || csum_bad) begin
                state      <= DROP;
                drop_count <= drop_inc;
              end else begin
                state <= UDP_HDR;
              end
            end
          end
        end

        UDP_HDR: begin
          if (accept) begin
            cnt    <= cnt + 5'd1;
            reject <= reject | udp_bad;
            if (cnt <= 5'd1)                 port_q <= {port_q[7:0], s_axis_tdata};
            if (cnt == 5'd4 || cnt == 5'd5)  len_q  <= {len_q[7:0], s_axis_tdata};
            if (s_axis_tlast) begin
              state      <= IDLE;
              drop_count <= drop_inc;
            end else if (cnt == 5'd7) begin
              if (reject) begin
                state      <= DROP;
                drop_count <= drop_inc;
              end else begin
                meta_valid    <= 1'b1;
                meta_src_mac  <= mac_q;
                meta_src_ip   <= ip_q;
                meta_src_port <= port_q;
                meta_len      <= len_q - 16'd8;
                remaining     <= len_q - 16'd8;
                state         <= (len_q == 16'd8) ? DROP : PAYLOAD;
              end
            end
          end
        end

        PAYLOAD: begin
          if (accept) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            remaining     <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= 1'b0;
              state        <= s_axis_tlast ? IDLE : DROP;
            end else if (s_axis_tlast) begin
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= 1'b1;
              state        <= IDLE;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
            end
          end
        end

        DROP: begin
          if (accept && s_axis_tlast) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: frame-level reference model plus directed frames.
module tb_udp_rx_parser;

  localparam logic [31:0] LIP   = 32'hC0A8010A;
  localparam logic [15:0] LPORT = 16'd5000;

  logic        clk = 1'b0;
  logic        rst;
  logic        header_valid;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        header_rd;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic        meta_valid;
  logic [47:0] meta_src_mac;
  logic [31:0] meta_src_ip;
  logic [15:0] meta_src_port;
  logic [15:0] meta_len;
  logic [15:0] drop_count;

  udp_rx_parser #(.LOCAL_IP(LIP), .LOCAL_PORT(LPORT)) dut (
    .clk(clk), .rst(rst),
    .header_valid(header_valid), .src_mac(src_mac), .ethertype(ethertype), .header_rd(header_rd),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .meta_valid(meta_valid), .meta_src_mac(meta_src_mac), .meta_src_ip(meta_src_ip),
    .meta_src_port(meta_src_port), .meta_len(meta_len), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] len;
  } meta_t;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  frm[$];
  logic [7:0]  pay[$];
  logic [7:0]  ip_b6 = 8'h40;
  logic [9:0]  exp_beats[$];
  meta_t       exp_meta[$];
  logic [15:0] exp_drop = 16'd0;
  int          exp_hdr = 0;
  int          hdr_seen = 0;
  int          n_beats = 0;
  logic [7:0]  last_data = 8'h00;
  logic        last_user = 1'b0;
  logic        bp_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout", name);
  endtask

  function automatic logic [15:0] ones_sum(input int nwords);
    int s = 0;
    for (int k = 0; k < nwords; k++) begin
      s = s + {frm[2*k], frm[2*k+1]};
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    end
    return 16'(s);
  endfunction

  // Assemble IPv4 + UDP headers, the global payload and zero padding into frm.
  task automatic build(input logic [31:0] dip, input logic [15:0] dport, input logic [15:0] ulen,
                       input int npad, input logic [15:0] csum_adj);
    logic [15:0] tot;
    logic [15:0] c;
    tot = 16'd20 + ulen;
    frm.delete();
    frm = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h01, ip_b6, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h64, dip[31:24], dip[23:16], dip[15:8], dip[7:0]};
    c = ~ones_sum(10) + csum_adj;
    frm[10] = c[15:8];
    frm[11] = c[7:0];
    frm.push_back(8'h04); frm.push_back(8'hD2);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    foreach (pay[i]) frm.push_back(pay[i]);
    for (int i = 0; i < npad; i++) frm.push_back(8'h00);
  endtask

  function automatic void bump();
    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
  endfunction

  // Frame-level reference: decides accept/drop from header fields and lists expected outputs.
  task automatic model_frame(input logic [15:0] et, input logic [47:0] mac);
    int n;
    int avail;
    int nb;
    logic [15:0] ulen;
    logic [15:0] plen;
    meta_t m;
    n = frm.size();
    exp_hdr++;
    if (et != 16'h0800 || n <= 28) begin bump(); return; end
    if (frm[0] != 8'h45 || frm[9] != 8'd17 || (frm[6] & 8'h3F) != 8'h00 || frm[7] != 8'h00 ||
        {frm[16], frm[17], frm[18], frm[19]} != LIP) begin bump(); return; end
`ifdef UDP_RX_IP_CSUM_EN
    if (ones_sum(10) != 16'hFFFF) begin bump(); return; end
`endif
    ulen = {frm[24], frm[25]};
    if ({frm[22], frm[23]} != LPORT || ulen < 16'd8) begin bump(); return; end
    plen = ulen - 16'd8;
    m.mac = mac; m.ip = {frm[12], frm[13], frm[14], frm[15]};
    m.port = {frm[20], frm[21]}; m.len = plen;
    exp_meta.push_back(m);
    avail = n - 28;
    nb = (int'(plen) < avail) ? int'(plen) : avail;
    for (int i = 0; i < nb; i++)
      exp_beats.push_back({(i == nb - 1) && (avail < int'(plen)), i == nb - 1, frm[28 + i]});
  endtask

  // Header handshake then byte stream; stop_at >= 0 sends only that many bytes without tlast.
  task automatic send_frame(input logic [15:0] et, input logic [47:0] mac, input int stop_at);
    int t;
    int n;
    bit hs;
    if (stop_at < 0) model_frame(et, mac);
    n = (stop_at < 0) ? frm.size() : stop_at;
    @(negedge clk);
    header_valid = 1'b1; ethertype = et; src_mac = mac;
    t = 0;
    while (header_rd !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("header_rd_wait");
    header_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata = frm[i]; s_axis_tvalid = 1'b1; s_axis_tlast = (stop_at < 0) && (i == n - 1);
      t = 0; hs = 1'b0;
      while (!hs && t < 200) begin
        #1; hs = s_axis_tready;
        @(negedge clk); t++;
      end
      if (!hs) begin fail("s_axis_tready_wait"); break; end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_beats.size() != 0 || m_axis_tvalid) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) fail({name, "_drain"});
    repeat (4) @(negedge clk);
    chk({name, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
    chk({name, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
    chk({name, "_meta_left"}, 64'(exp_meta.size()), 64'd0);
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // Output compare process: beats, metadata, header pops and stall stability.
  initial begin
    logic        prev_stall;
    logic [9:0]  prev_beat;
    logic [9:0]  e;
    meta_t       em;
    prev_stall = 1'b0; prev_beat = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin prev_stall = 1'b0; continue; end
      if (header_rd) hdr_seen++;
      if (prev_stall) chk("stall_hold", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}),
                          64'({1'b1, prev_beat}));
      if (m_axis_tvalid && !m_axis_tready && bp_mode) chk("stall_sready", 64'(s_axis_tready), 64'd0);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", 64'(prev_beat), 64'h3FF);
        else begin
          e = exp_beats.pop_front();
          chk("beat", 64'(prev_beat), 64'(e));
        end
        n_beats++; last_data = m_axis_tdata; last_user = m_axis_tuser;
      end
      if (meta_valid) begin
        if (exp_meta.size() == 0) chk("unexpected_meta", 64'(meta_len), 64'hFFFF_FFFF);
        else begin
          em = exp_meta.pop_front();
          chk("meta", 64'(meta_src_mac), 64'(em.mac));
          chk("meta_fields", {meta_src_ip, meta_src_port, meta_len}, {em.ip, em.port, em.len});
        end
      end
    end
  end

  initial begin
    int h0;
    rst = 1'b1; header_valid = 1'b0; src_mac = '0; ethertype = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({header_rd, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, meta_valid}), 64'd0);
    chk("rst_meta", 64'({meta_src_ip, meta_src_port, meta_len}), 64'd0);
    chk("rst_meta_mac", 64'(meta_src_mac), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;

    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build(LIP, LPORT, 16'd12, 0, 16'd0);
    n_beats = 0; h0 = hdr_seen;
    send_frame(16'h0800, 48'h0200_0000_0001, -1);
    drain("valid");
    chk("valid_nbeats", 64'(n_beats), 64'd4);
    chk("valid_last", 64'({last_user, last_data}), 64'h0EF);
    chk("valid_meta_len", 64'(meta_len), 64'd4);
    chk("valid_meta_ip", 64'(meta_src_ip), 64'hC0A8_0164);
    chk("valid_hdr", 64'(hdr_seen - h0), 64'd1);
    chk("valid_drop_lit", 64'(drop_count), 64'd0);

    pay = '{8'h5A};
    build(LIP, LPORT, 16'd9, 17, 16'd0);
    n_beats = 0;
    send_frame(16'h0800, 48'h0200_0000_0002, -1);
    drain("padded");
    chk("padded_nbeats", 64'(n_beats), 64'd1);
    chk("padded_last", 64'(last_data), 64'h5A);

    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    build(LIP, LPORT, 16'd12, 0, 16'd0);
    send_frame(16'h0800, 48'h0200_0000_0003, -1);
    drain("after_pad");

    n_beats = 0; h0 = hdr_seen;
    send_frame(16'h0806, 48'h0200_0000_0004, -1);
    build(32'hC0A8010B, LPORT, 16'd12, 0, 16'd0);
    send_frame(16'h0800, 48'h0200_0000_0005, -1);
    build(LIP, 16'd5001, 16'd12, 0, 16'd0);
    send_frame(16'h0800, 48'h0200_0000_0006, -1);
    drain("rejects");
    chk("rejects_drop_lit", 64'(drop_count), 64'd3);
    chk("rejects_nbeats", 64'(n_beats), 64'd0);
    chk("rejects_hdr", 64'(hdr_seen - h0), 64'd3);

    pay.delete();
    for (int i = 0; i < 50; i++) pay.push_back(8'(i * 3 + 1));
    build(LIP, LPORT, 16'd108, 0, 16'd0);
    n_beats = 0;
    send_frame(16'h0800, 48'h0200_0000_0007, -1);
    drain("trunc");
    chk("trunc_nbeats", 64'(n_beats), 64'd50);
    chk("trunc_last", 64'({last_user, last_data}), 64'h194);

    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'(i * 7 + 3));
    build(LIP, LPORT, 16'd24, 0, 16'd0);
    bp_mode = 1'b1;
    send_frame(16'h0800, 48'h0200_0000_0008, -1);
    drain("backpressure");
    bp_mode = 1'b0;

    pay.delete();
    build(LIP, LPORT, 16'd8, 10, 16'd0);
    send_frame(16'h0800, 48'h0200_0000_0009, -1);
    drain("len_zero");
    chk("len_zero_meta", 64'(meta_len), 64'd0);

    build(LIP, LPORT, 16'd4, 10, 16'd0);
    send_frame(16'h0800, 48'h0200_0000_000A, -1);
    drain("len_short");

    ip_b6 = 8'h20;
    pay = '{8'h01, 8'h02};
    build(LIP, LPORT, 16'd10, 0, 16'd0);
    ip_b6 = 8'h40;
    send_frame(16'h0800, 48'h0200_0000_000B, -1);
    drain("mf_flag");

    build(LIP, LPORT, 16'd10, 0, 16'd0);
    while (frm.size() > 10) void'(frm.pop_back());
    send_frame(16'h0800, 48'h0200_0000_000C, -1);
    drain("short_frame");
    chk("short_drop_lit", 64'(drop_count), 64'd6);

`ifdef UDP_RX_IP_CSUM_EN
    build(LIP, LPORT, 16'd10, 0, 16'd1);
    send_frame(16'h0800, 48'h0200_0000_000D, -1);
    drain("csum_bad");
    chk("csum_bad_drop_lit", 64'(drop_count), 64'd7);
    build(LIP, LPORT, 16'd10, 0, 16'd0);
    send_frame(16'h0800, 48'h0200_0000_000E, -1);
    drain("csum_good");
`endif

    chk("hdr_count", 64'(hdr_seen), 64'(exp_hdr));

    build(LIP, LPORT, 16'd12, 0, 16'd0);
    send_frame(16'h0800, 48'h0200_0000_000F, 15);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_out", 64'({m_axis_tvalid, meta_valid, s_axis_tready, header_rd}), 64'd0);
    chk("midrst_regs", 64'({drop_count, meta_len}), 64'd0);
    rst = 1'b0;
    exp_drop = 16'd0;
    exp_beats.delete(); exp_meta.delete();
    pay = '{8'hCA, 8'hFE};
    build(LIP, LPORT, 16'd10, 0, 16'd0);
    n_beats = 0;
    send_frame(16'h0800, 48'h0200_0000_0010, -1);
    drain("post_rst");
    chk("post_rst_nbeats", 64'(n_beats), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Sits directly downstream of the RMII packet receiver and consumes its two outputs:
  - the header FIFO interface (header_valid/dest_mac/src_mac/ethertype/header_rd);
  - the byte AXI-stream data path.
- Filters for IPv4/UDP frames addressed to the local IP and port.
- Strips the IPv4 and UDP headers, trims Ethernet padding, and emits the UDP payload as an AXI-stream with per-datagram metadata.
- Every other frame is consumed and discarded.

Parameters:
- LOCAL_IP, 32'hC0A8010A, accepted IPv4 destination address (192.168.1.10).
- LOCAL_PORT, 16'd5000, accepted UDP destination port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- header_valid  in  1  receiver header FIFO not empty
- src_mac  in  48  source MAC of the current header
- ethertype  in  16  ethertype of the current header
- header_rd  out  1  one-cycle pop of the header FIFO
- s_axis_tdata  in  8  frame byte (first byte = first byte after the Ethernet header)
- s_axis_tvalid  in  1
- s_axis_tlast  in  1
- s_axis_tready  out  1
- m_axis_tdata  out  8  UDP payload byte
- m_axis_tvalid  out  1
- m_axis_tlast  out  1
- m_axis_tuser  out  1  1 = datagram truncated (frame ended before the UDP length was reached)
- m_axis_tready  in  1
- meta_valid  out  1  one-cycle pulse per accepted datagram
- meta_src_mac  out  48  held stable from the meta_valid pulse until the next accepted datagram
- meta_src_ip  out  32
- meta_src_port  out  16
- meta_len  out  16  payload length = UDP length − 8
- drop_count  out  16  saturating count of discarded frames

Behaviour:
- Reset values:
  - header_rd, s_axis_tready, m_axis_tvalid/tlast/tuser, meta_valid = 0.
  - All meta_* outputs = 0; drop_count = 0.
  - State = IDLE.
  - A reset mid-frame abandons the frame and returns to IDLE; no output beat and no count update.
- IDLE:
  - s_axis_tready = 0.
  - When header_valid = 1: assert header_rd for exactly one cycle, latch src_mac and ethertype, go to IP_HDR.
  - If ethertype != 16'h0800, go to DROP instead.
- IP_HDR:
  - s_axis_tready = 1; accept 20 bytes, tracked by a byte counter 0..19 big-endian.
  - Byte 0 must be 8'h45; byte 9 must be 8'd17.
  - Bytes 6–7: MF flag and fragment offset must both be 0.
  - Bytes 12–15 are latched as src_ip; bytes 16–19 must equal LOCAL_IP.
  - Any failure sets a sticky reject flag. After byte 19: reject → DROP, else → UDP_HDR.
- UDP_HDR:
  - Accept 8 bytes: src_port (0–1), dst_port (2–3), length (4–5); checksum (6–7) is ignored.
  - Reject if dst_port != LOCAL_PORT or length < 8.
  - After byte 7 with no reject: update meta_* registers and pulse meta_valid on the next cycle.
  - If meta_len = 0 → DROP with no payload beat, and drop_count is not incremented. Otherwise → PAYLOAD.
- PAYLOAD:
  - Single-register output stage: s_axis_tready = ~m_axis_tvalid | m_axis_tready.
  - A 16-bit remaining counter is loaded with meta_len and decrements per accepted byte.
  - Beat with remaining = 1: m_axis_tlast = 1, tuser = 0. If s_axis_tlast is not also set → DROP (padding/FCS residue), otherwise → IDLE.
  - s_axis_tlast with remaining > 1: m_axis_tlast = 1, m_axis_tuser = 1 → IDLE.
  - Output data/tlast/tuser are held stable while tvalid = 1 and tready = 0.
- DROP:
  - s_axis_tready = 1; consume bytes until s_axis_tlast, then → IDLE.
  - Entering DROP from any reject increments drop_count, saturating at 16'hFFFF.
  - Padding-trim entry does not increment drop_count.
- Any state: s_axis_tlast arriving during IP_HDR or UDP_HDR ends the frame → IDLE, drop_count + 1, no meta_valid.
- Header pop and data never desynchronise: exactly one header_rd per frame, issued only from IDLE.

Optional Feature:
- Macro: UDP_RX_IP_CSUM_EN.
- Defined:
  - In IP_HDR, accumulate the 16-bit ones-complement sum of the ten header words with end-around carry.
  - After byte 19, a result != 16'hFFFF sets reject → DROP, drop_count + 1.
- Undefined: the checksum bytes are ignored and no adder is built.

Test Plan:
- Valid frame:
  - Stimulus: ethertype 0800, dst 192.168.1.10, dst port 5000, UDP length 12, bytes DE AD BE EF, m_axis_tready = 1.
  - Response: one header_rd; meta_valid with meta_len = 4; payload DE AD BE EF with tlast on EF, tuser = 0; drop_count = 0.
- Padded frame: UDP length 9, one payload byte 0x5A followed by 17 pad bytes → single beat 5A with tlast = 1; pad bytes consumed; drop_count unchanged; next frame parsed correctly.
- Rejects: ethertype 0806, wrong IP 192.168.1.11, and port 5001, sent back-to-back → no m_axis beats, no meta_valid, drop_count = 3, three header_rd pulses.
- Truncation: UDP length 108, frame ends after 50 payload bytes → 50 beats, last with tlast = 1 and tuser = 1.
- Backpressure: valid frame with m_axis_tready toggling 1010… → byte order preserved; tdata stable while stalled; s_axis_tready low whenever the output is stalled.
- With UDP_RX_IP_CSUM_EN: corrupt IP checksum word by +1 → frame dropped, drop_count + 1. The same frame with the correct checksum passes.
